// File: rtl/fft_input_load_ctrl.sv
// fft_input_load_ctrl: steers upstream samples into the FFT input segments and hands full frames to the core
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : upstream sample handshake (data goes straight to segment D inputs)
//   abort              : drop the partially loaded frame
//   fft_done           : core has consumed the frame
//   seg_hold           : per-segment hold, 0 releases that segment to shift in D
//   seg_sel/sample_cnt : segment being filled / samples accepted this frame
//   fft_start/busy     : frame-ready pulse / frame owned by core
//   done_err           : sticky, fft_done seen while not waiting for it
module fft_input_load_ctrl #(
   parameter int NUM_SEGS  = 8,
   parameter int SEG_DEPTH = 8,
   parameter int CNT_WIDTH = 6,
   parameter int SEL_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 abort,
   input  logic                 fft_done,
   output logic [NUM_SEGS-1:0]  seg_hold,
   output logic [SEL_WIDTH-1:0] seg_sel,
   output logic [CNT_WIDTH-1:0] sample_cnt,
   output logic                 fft_start,
   output logic                 busy,
   output logic                 done_err
);
   typedef enum logic [1:0] {LOAD, START, WAIT_DONE} state_t;
   state_t state;
   logic accept;
   logic last;
   assign in_ready = (state == LOAD) && !rst;
   assign accept   = in_ready && in_valid && !abort;
   assign seg_sel  = sample_cnt[CNT_WIDTH-1 -: SEL_WIDTH];
   assign last     = sample_cnt == CNT_WIDTH'(NUM_SEGS*SEG_DEPTH-1);
   // the released segment shifts on the same edge that accepts the sample
   for (genvar g = 0; g < NUM_SEGS; g++) begin : g_hold
      assign seg_hold[g] = ~(accept && seg_sel == SEL_WIDTH'(g));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= LOAD;
         sample_cnt <= '0;
         fft_start  <= 1'b0;
         busy       <= 1'b0;
         done_err   <= 1'b0;
      end else begin
         if (fft_done && state != WAIT_DONE) done_err <= 1'b1;
         case (state)
            LOAD:
               if (abort) sample_cnt <= '0;
               else if (accept) begin
                  sample_cnt <= sample_cnt + 1'b1;
                  if (last) begin
                     state     <= START;
                     fft_start <= 1'b1;
                     busy      <= 1'b1;
                  end
               end
            START: begin
               state     <= WAIT_DONE;
               fft_start <= 1'b0;
            end
            WAIT_DONE:
               if (fft_done) begin
                  state      <= LOAD;
                  busy       <= 1'b0;
                  sample_cnt <= '0;
               end
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_fft_input_load_ctrl.sv
// tb_fft_input_load_ctrl: directed self-checking bench with a behavioural model of the segment shift chains
module tb_fft_input_load_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       abort = 1'b0;
   logic       fft_done = 1'b0;
   logic       in_ready;
   logic [7:0] seg_hold;
   logic [2:0] seg_sel;
   logic [5:0] sample_cnt;
   logic       fft_start;
   logic       busy;
   logic       done_err;
   logic [7:0] data = 8'd0;
   logic [7:0] seg [8][8];
   int         passed = 0;
   int         total = 0;

   fft_input_load_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .abort(abort),
      .fft_done(fft_done), .seg_hold(seg_hold), .seg_sel(seg_sel), .sample_cnt(sample_cnt),
      .fft_start(fft_start), .busy(busy), .done_err(done_err)
   );

   always #5 clk = ~clk;

   // external 8-deep segments: [0] takes D, [7] is the segment output
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < 8; s++)
            for (int j = 0; j < 8; j++) seg[s][j] <= 8'd0;
      end else begin
         for (int s = 0; s < 8; s++)
            if (!seg_hold[s]) begin
               seg[s][0] <= data;
               for (int j = 1; j < 8; j++) seg[s][j] <= seg[s][j-1];
            end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic load_n(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         data = 8'(base + i);
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic finish_frame;
      fft_done = 1'b1;
      step();
      fft_done = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      in_valid = 1'b1;
      step();
      step();
      total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else passed++;
      total++; if (seg_hold !== 8'hFF) $display("FAIL rst_hold got %h want ff", seg_hold); else passed++;
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      total++; if (sample_cnt !== 6'd0) $display("FAIL rst_cnt got %0d want 0", sample_cnt); else passed++;
      total++; if (seg_sel !== 3'd0) $display("FAIL rst_sel got %0d want 0", seg_sel); else passed++;
      total++; if ({fft_start, busy, done_err} !== 3'b000) $display("FAIL rst_flags got %b want 000", {fft_start, busy, done_err}); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL rst_ready_after got %b want 1", in_ready); else passed++;
   endtask

   task automatic test_full_frame;
      for (int i = 0; i < 64; i++) begin
         in_valid = 1'b1;
         data = 8'(i);
         #1;
         total++; if (seg_hold !== ~(8'd1 << (i / 8))) $display("FAIL ff_hold[%0d] got %h want %h", i, seg_hold, ~(8'd1 << (i / 8))); else passed++;
         total++; if (sample_cnt !== 6'(i) || seg_sel !== 3'(i / 8)) $display("FAIL ff_cnt[%0d] got cnt %0d sel %0d want %0d %0d", i, sample_cnt, seg_sel, i, i / 8); else passed++;
         total++; if (fft_start !== 1'b0) $display("FAIL ff_early_start[%0d] got %b want 0", i, fft_start); else passed++;
         step();
      end
      in_valid = 1'b0;
      #1;
      total++; if ({fft_start, busy, in_ready} !== 3'b110) $display("FAIL ff_start got start/busy/ready %b want 110", {fft_start, busy, in_ready}); else passed++;
      total++; if (sample_cnt !== 6'd0) $display("FAIL ff_wrap got %0d want 0", sample_cnt); else passed++;
      step();
      total++; if ({fft_start, busy} !== 2'b01) $display("FAIL ff_pulse got start/busy %b want 01", {fft_start, busy}); else passed++;
      for (int k = 0; k < 8; k++) begin
         total++; if (seg[k][7] !== 8'(8 * k) || seg[k][0] !== 8'(8 * k + 7)) $display("FAIL ff_seg%0d got %0d..%0d want %0d..%0d", k, seg[k][7], seg[k][0], 8 * k, 8 * k + 7); else passed++;
      end
   endtask

   task automatic test_wait_done;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         total++; if (in_ready !== 1'b0 || seg_hold !== 8'hFF || busy !== 1'b1) $display("FAIL wd_idle[%0d] got ready %b hold %h busy %b want 0 ff 1", i, in_ready, seg_hold, busy); else passed++;
         step();
      end
      in_valid = 1'b0;
      finish_frame();
      total++; if (in_ready !== 1'b1 || sample_cnt !== 6'd0 || busy !== 1'b0) $display("FAIL wd_release got ready %b cnt %0d busy %b want 1 0 0", in_ready, sample_cnt, busy); else passed++;
      total++; if (done_err !== 1'b0) $display("FAIL wd_err got %b want 0", done_err); else passed++;
   endtask

   task automatic test_gaps;
      for (int i = 0; i < 128; i++) begin
         in_valid = (i % 2 == 0);
         data = 8'(i / 2);
         #1;
         total++; if (sample_cnt !== 6'((i + 1) / 2)) $display("FAIL gap_cnt[%0d] got %0d want %0d", i, sample_cnt, ((i + 1) / 2) % 64); else passed++;
         if (i % 2 == 1) begin
            total++; if (seg_hold !== 8'hFF) $display("FAIL gap_idle_hold[%0d] got %h want ff", i, seg_hold); else passed++;
         end
         total++; if (fft_start !== (i == 127)) $display("FAIL gap_start[%0d] got %b want %b", i, fft_start, i == 127); else passed++;
         step();
      end
      in_valid = 1'b0;
      total++; if (seg[3][7] !== 8'd24 || seg[7][0] !== 8'd63) $display("FAIL gap_seg got %0d %0d want 24 63", seg[3][7], seg[7][0]); else passed++;
      finish_frame();
   endtask

   task automatic test_abort;
      load_n(20, 200);
      total++; if (sample_cnt !== 6'd20) $display("FAIL ab_pre got %0d want 20", sample_cnt); else passed++;
      abort = 1'b1;
      in_valid = 1'b1;
      #1;
      total++; if (seg_hold !== 8'hFF) $display("FAIL ab_hold got %h want ff", seg_hold); else passed++;
      step();
      abort = 1'b0;
      in_valid = 1'b0;
      total++; if (sample_cnt !== 6'd0 || seg_sel !== 3'd0) $display("FAIL ab_clear got cnt %0d sel %0d want 0 0", sample_cnt, seg_sel); else passed++;
      for (int i = 0; i < 64; i++) begin
         in_valid = 1'b1;
         data = 8'(100 + i);
         #1;
         total++; if (fft_start !== 1'b0) $display("FAIL ab_early_start[%0d] got %b want 0", i, fft_start); else passed++;
         step();
      end
      in_valid = 1'b0;
      total++; if (fft_start !== 1'b1) $display("FAIL ab_start got %b want 1", fft_start); else passed++;
      step();
      total++; if (fft_start !== 1'b0) $display("FAIL ab_single got %b want 0", fft_start); else passed++;
      total++; if (seg[0][7] !== 8'd100 || seg[2][7] !== 8'd116) $display("FAIL ab_seg got %0d %0d want 100 116", seg[0][7], seg[2][7]); else passed++;
      finish_frame();
   endtask

   task automatic test_done_err;
      load_n(5, 0);
      total++; if (sample_cnt !== 6'd5) $display("FAIL de_pre got %0d want 5", sample_cnt); else passed++;
      finish_frame();
      total++; if (done_err !== 1'b1) $display("FAIL de_set got %b want 1", done_err); else passed++;
      total++; if (sample_cnt !== 6'd5 || in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL de_noeffect got cnt %0d ready %b busy %b want 5 1 0", sample_cnt, in_ready, busy); else passed++;
      load_n(1, 0);
      total++; if (sample_cnt !== 6'd6 || done_err !== 1'b1) $display("FAIL de_continue got cnt %0d err %b want 6 1", sample_cnt, done_err); else passed++;
   endtask

   task automatic test_reset_mid;
      load_n(34, 0);
      total++; if (sample_cnt !== 6'd40) $display("FAIL rm_pre got %0d want 40", sample_cnt); else passed++;
      rst = 1'b1;
      in_valid = 1'b1;
      #1;
      total++; if (seg_hold !== 8'hFF || in_ready !== 1'b0) $display("FAIL rm_hold got hold %h ready %b want ff 0", seg_hold, in_ready); else passed++;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      total++; if (sample_cnt !== 6'd0 || done_err !== 1'b0 || busy !== 1'b0) $display("FAIL rm_clear got cnt %0d err %b busy %b want 0 0 0", sample_cnt, done_err, busy); else passed++;
      for (int i = 0; i < 30; i++) begin
         total++; if (fft_start !== 1'b0) $display("FAIL rm_nostart[%0d] got %b want 0", i, fft_start); else passed++;
         step();
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_wait_done();
      test_gaps();
      test_abort();
      test_done_err();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
